// File: rtl/kulisch_pkg.sv
// Shared widths, float field layout and helpers for the Kulisch-to-float converter.
package kulisch_pkg;

  localparam int DEF_ACC_WIDTH = 32;
  localparam int DEF_EXP_OUT   = 5;
  localparam int DEF_FRAC_OUT  = 10;

  localparam int FRAC_LSB = 0;
  localparam int EXP_LSB  = DEF_FRAC_OUT;
  localparam int SIGN_BIT = DEF_FRAC_OUT + DEF_EXP_OUT;

  typedef struct packed {
    logic                    sign;
    logic [DEF_EXP_OUT-1:0]  exp;
    logic [DEF_FRAC_OUT-1:0] frac;
  } kfloat_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/kulisch_lzc.sv
// Leading-one detector: position of the most significant set bit, plus an all-zero flag.
module kulisch_lzc #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]         value_i,
  output logic [$clog2(WIDTH)-1:0] pos_o,
  output logic                     zero_o
);

  localparam int PW = $clog2(WIDTH);

  logic [PW-1:0] pos_s;

  // Scan upward so the highest set bit is the last one to win.
  always_comb begin
    pos_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pos_s = value_i[i] ? PW'(i) : pos_s;
    end
  end

  assign pos_o  = pos_s;
  assign zero_o = ~|value_i;

endmodule

// File: rtl/kulisch_to_float.sv
// Converts a two's-complement Kulisch accumulator into a small sign-magnitude float.
// Input capture, then S1 sign/abs, S2 normalise/align, S3 round/pack; one global stall.
module kulisch_to_float
  import kulisch_pkg::*;
#(
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int EXP_OUT   = DEF_EXP_OUT,
  parameter int FRAC_OUT  = DEF_FRAC_OUT
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ACC_WIDTH-1:0]          accIn,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [EXP_OUT+FRAC_OUT:0]     out
);

  localparam int PW = $clog2(ACC_WIDTH);
  localparam int EW = max_int(PW + 2, EXP_OUT + 2);
  localparam int MW = FRAC_OUT + 1;
  localparam int OW = 1 + EXP_OUT + FRAC_OUT;

  localparam logic [PW-1:0]        FRAC_P   = PW'(FRAC_OUT);
  localparam logic [PW-1:0]        ONE_P    = PW'(1);
  localparam logic [ACC_WIDTH-1:0] ONE_ACC  = ACC_WIDTH'(1);
  localparam logic [EW-1:0]        EXP_BIAS = EW'(FRAC_OUT - 1);
  localparam logic [EW-1:0]        EXP_MAX  = EW'((1 << EXP_OUT) - 1);

  logic advance_s;

  logic                 s0_valid_q;
  logic [ACC_WIDTH-1:0] s0_acc_q;

  logic                 s1_valid_q;
  logic                 s1_sign_q;
  logic [ACC_WIDTH-1:0] s1_mag_q;
  logic                 s1_sign_d;
  logic [ACC_WIDTH-1:0] s1_mag_d;

  logic                 s2_valid_q;
  logic                 s2_sign_q;
  logic                 s2_zero_q;
  logic [EW-1:0]        s2_exp_q;
  logic [MW-1:0]        s2_mant_q;
  logic                 s2_guard_q;
  logic                 s2_sticky_q;
  logic [EW-1:0]        s2_exp_d;
  logic [MW-1:0]        s2_mant_d;
  logic                 s2_guard_d;
  logic                 s2_sticky_d;

  logic [PW-1:0]        p_s;
  logic                 zero_s;
  logic [PW-1:0]        shift_s;
  logic [ACC_WIDTH-1:0] gmask_s;

  logic                 s3_valid_q;
  logic [OW-1:0]        out_q;
  logic [OW-1:0]        out_d;
  logic                 round_up_s;
  logic                 carry_s;
  logic [FRAC_OUT-1:0]  frac_sum_s;
  logic [FRAC_OUT-1:0]  frac_s;
  logic [EW-1:0]        exp_fin_s;

  assign in_ready  = !s3_valid_q || out_ready;
  assign advance_s = in_ready;
  assign out_valid = s3_valid_q;
  assign out       = out_q;

  // S1: magnitude in unsigned ACC_WIDTH bits, so the most negative value maps to 2^(ACC_WIDTH-1).
  always_comb begin
    s1_sign_d = s0_acc_q[ACC_WIDTH-1];
    if (s1_sign_d) begin
      s1_mag_d = ~s0_acc_q + ONE_ACC;
    end else begin
      s1_mag_d = s0_acc_q;
    end
  end

  kulisch_lzc #(
    .WIDTH (ACC_WIDTH)
  ) u_lzc (
    .value_i (s1_mag_q),
    .pos_o   (p_s),
    .zero_o  (zero_s)
  );

  // S2: place the leading one at mantissa bit FRAC_OUT and collect guard/sticky from the dropped bits.
  always_comb begin
    shift_s     = '0;
    gmask_s     = '0;
    s2_exp_d    = '0;
    s2_mant_d   = '0;
    s2_guard_d  = 1'b0;
    s2_sticky_d = 1'b0;
    if (p_s > FRAC_P) begin
      shift_s     = p_s - FRAC_P;
      gmask_s     = ONE_ACC << (shift_s - ONE_P);
      s2_mant_d   = MW'(s1_mag_q >> shift_s);
      s2_guard_d  = |(s1_mag_q & gmask_s);
      s2_sticky_d = |(s1_mag_q & (gmask_s - ONE_ACC));
      s2_exp_d    = EW'(p_s) - EXP_BIAS;
    end else if (p_s == FRAC_P) begin
      s2_mant_d = s1_mag_q[FRAC_OUT:0];
      s2_exp_d  = EW'(1);
    end else begin
      s2_mant_d = s1_mag_q[FRAC_OUT:0];
      s2_exp_d  = '0;
    end
  end

  assign round_up_s = s2_guard_q & (s2_sticky_q | s2_mant_q[0]);
  assign carry_s    = round_up_s & (&s2_mant_q);
  assign frac_sum_s = s2_mant_q[FRAC_OUT-1:0] + FRAC_OUT'(round_up_s);

  // S3: round to nearest even, renormalise on carry, saturate instead of overflowing.
  always_comb begin
    frac_s    = frac_sum_s;
    exp_fin_s = s2_exp_q;
    out_d     = '0;
    if (carry_s) begin
      exp_fin_s = s2_exp_q + EW'(1);
    end else begin
      exp_fin_s = s2_exp_q;
    end
    if (s2_zero_q) begin
      out_d = '0;
    end else if (exp_fin_s > EXP_MAX) begin
      out_d = {s2_sign_q, {EXP_OUT{1'b1}}, {FRAC_OUT{1'b1}}};
    end else begin
      out_d = {s2_sign_q, exp_fin_s[EXP_OUT-1:0], frac_s};
    end
  end

  // Valid flags and the output register, all moving together on the global enable.
  always_ff @(posedge clock) begin
    if (reset) begin
      s0_valid_q <= 1'b0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      out_q      <= '0;
    end else if (advance_s) begin
      s0_valid_q <= in_valid;
      s1_valid_q <= s0_valid_q;
      s2_valid_q <= s1_valid_q;
      s3_valid_q <= s2_valid_q;
      out_q      <= s2_valid_q ? out_d : '0;
    end
  end

  // Datapath stage registers; contents of bubble stages are don't-care.
  always_ff @(posedge clock) begin
    if (advance_s) begin
      s0_acc_q    <= accIn;
      s1_sign_q   <= s1_sign_d;
      s1_mag_q    <= s1_mag_d;
      s2_sign_q   <= s1_sign_q;
      s2_zero_q   <= zero_s;
      s2_exp_q    <= s2_exp_d;
      s2_mant_q   <= s2_mant_d;
      s2_guard_q  <= s2_guard_d;
      s2_sticky_q <= s2_sticky_d;
    end
  end

endmodule

// File: tb/tb_kulisch_to_float.sv
// Directed self-checking bench for kulisch_to_float (default build plus an EXP_OUT=3 build).
module tb_kulisch_to_float;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] accIn = 32'd0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out;

  logic        s_in_valid = 1'b0;
  logic        s_out_ready = 1'b1;
  logic [31:0] s_acc = 32'd0;
  logic        s_in_ready;
  logic        s_out_valid;
  logic [13:0] s_out;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  kulisch_to_float u_dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .accIn     (accIn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  kulisch_to_float #(
    .ACC_WIDTH (32),
    .EXP_OUT   (3),
    .FRAC_OUT  (10)
  ) u_sat (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .accIn     (s_acc),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out       (s_out)
  );

  // Push one value into an idle pipeline and wait (bounded) for its result.
  task automatic run_one(input bit sat, input logic [31:0] v, output logic [15:0] got, output int lat);
    got = 16'hxxxx;
    lat = -1;
    @(posedge clock); #1;
    if (sat) begin
      s_in_valid = 1'b1; s_acc = v; s_out_ready = 1'b1;
    end else begin
      in_valid = 1'b1; accIn = v; out_ready = 1'b1;
    end
    @(posedge clock); #1;
    in_valid   = 1'b0;
    s_in_valid = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      if (lat < 0) begin
        @(posedge clock); #1;
        if (sat ? s_out_valid : out_valid) begin
          got = sat ? {2'b00, s_out} : out;
          lat = n;
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out !== 16'h0000) begin bad++; $display("FAIL reset_out got=%h want=0000", out); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (s_out_valid !== 1'b0) begin bad++; $display("FAIL reset_sat_valid got=%b want=0", s_out_valid); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] vin  [3] = '{32'd1, 32'd1500, 32'hFFFF_FFFD};
    logic [15:0] vexp [3] = '{16'h0001, 16'h05DC, 16'h8003};
    logic [15:0] got;
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_one(1'b0, vin[i], got, lat);
      total++; if (got !== vexp[i]) begin bad++; $display("FAIL basic[%0d] out=%h want=%h", i, got, vexp[i]); end
      total++; if (lat !== 3) begin bad++; $display("FAIL basic_latency[%0d] cycles=%0d want=3", i, lat); end
    end
  endtask

  task automatic test_rounding();
    logic [31:0] vin  [5] = '{32'd4097, 32'd4098, 32'd4102, 32'd8190, 32'd131071};
    logic [15:0] vexp [5] = '{16'h0C00, 16'h0C00, 16'h0C02, 16'h1000, 16'h2000};
    logic [15:0] got;
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_one(1'b0, vin[i], got, lat);
      total++; if (got !== vexp[i]) begin bad++; $display("FAIL round[%0d] in=%0d out=%h want=%h", i, vin[i], got, vexp[i]); end
    end
  endtask

  task automatic test_special();
    logic [31:0] vin  [6] = '{32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'd1023, 32'd1024, 32'h7FFF_FFFF};
    logic [15:0] vexp [6] = '{16'hD800, 16'h0000, 16'h8001, 16'h03FF, 16'h0400, 16'h5800};
    logic [15:0] got;
    int lat;
    for (int i = 0; i < 6; i++) begin
      run_one(1'b0, vin[i], got, lat);
      total++; if (got !== vexp[i]) begin bad++; $display("FAIL special[%0d] in=%h out=%h want=%h", i, vin[i], got, vexp[i]); end
    end
  endtask

  task automatic test_saturate();
    logic [31:0] vin  [5] = '{32'h7FFF_FFFF, 32'h8000_0001, 32'd65536, 32'd131071, 32'd1500};
    logic [15:0] vexp [5] = '{16'h1FFF, 16'h3FFF, 16'h1C00, 16'h1FFF, 16'h05DC};
    logic [15:0] got;
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_one(1'b1, vin[i], got, lat);
      total++; if (got !== vexp[i]) begin bad++; $display("FAIL saturate[%0d] in=%h out=%h want=%h", i, vin[i], got, vexp[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vin  [8] = '{32'd1, 32'd1500, 32'hFFFF_FFFD, 32'd4097, 32'd4098, 32'd4102, 32'd8190, 32'd0};
    logic [15:0] vexp [8] = '{16'h0001, 16'h05DC, 16'h8003, 16'h0C00, 16'h0C00, 16'h0C02, 16'h1000, 16'h0000};
    int sent = 0;
    int rcvd = 0;
    int extra = 0;
    logic held_v = 1'b0;
    logic [15:0] held = 16'h0000;
    @(posedge clock); #1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (rcvd < 8) begin
        if (held_v) begin
          total++;
          if (out_valid !== 1'b1 || out !== held) begin
            bad++; $display("FAIL stall_hold out=%h valid=%b want=%h valid=1", out, out_valid, held);
          end
        end
        out_ready = ($urandom_range(0, 1) == 1);
        if (sent < 8) begin
          in_valid = 1'b1; accIn = vin[sent];
        end else begin
          in_valid = 1'b0; accIn = 32'd0;
        end
        #1;
        held_v = 1'b0;
        if (out_valid && out_ready) begin
          total++;
          if (out !== vexp[rcvd]) begin bad++; $display("FAIL stream[%0d] out=%h want=%h", rcvd, out, vexp[rcvd]); end
          rcvd++;
        end else if (out_valid) begin
          held_v = 1'b1;
          held   = out;
          total++;
          if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%b want=0", in_ready); end
        end else begin
          held_v = 1'b0;
        end
        if (in_valid && in_ready) sent++;
        @(posedge clock); #1;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    total++; if (rcvd !== 8) begin bad++; $display("FAIL stream_count got=%0d want=8", rcvd); end
    repeat (6) begin
      @(posedge clock); #1;
      if (out_valid) extra++;
    end
    total++; if (extra !== 0) begin bad++; $display("FAIL stream_extra got=%0d want=0", extra); end
  endtask

  task automatic test_reset_flush();
    int seen = 0;
    logic [15:0] got;
    int lat;
    @(posedge clock); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1; accIn = 32'd1;
    @(posedge clock); #1; accIn = 32'd2;
    @(posedge clock); #1; accIn = 32'd3;
    @(posedge clock); #1;
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b want=0", out_valid); end
    total++; if (out !== 16'h0000) begin bad++; $display("FAIL flush_out got=%h want=0000", out); end
    repeat (8) begin
      @(posedge clock); #1;
      if (out_valid) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL flush_leak got=%0d want=0", seen); end
    run_one(1'b0, 32'd1500, got, lat);
    total++; if (got !== 16'h05DC) begin bad++; $display("FAIL flush_recover out=%h want=05DC", got); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_special();
    test_saturate();
    test_back_to_back();
    test_reset_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kulisch_to_float.md
KULISCH_TO_FLOAT -- requirements
Module: kulisch_to_float

Interface
REQ-001 The module SHALL have parameter ACC_WIDTH, default 32, meaning the two's-complement Kulisch accumulator width.
REQ-002 The module SHALL have parameter EXP_OUT, default 5, meaning the output exponent field width.
REQ-003 The module SHALL have parameter FRAC_OUT, default 10, meaning the output fraction field width.
REQ-004 The module SHALL have port clock, input, 1 bit, meaning the rising-edge clock.
REQ-005 The module SHALL have port reset, input, 1 bit, meaning a synchronous, active-high reset.
REQ-006 The module SHALL have port in_valid, input, 1 bit, meaning accIn is valid.
REQ-007 The module SHALL have port in_ready, output, 1 bit, meaning the block accepts accIn this cycle.
REQ-008 The module SHALL have port accIn, input, ACC_WIDTH bits, meaning a two's-complement accumulator value in LSB units.
REQ-009 The module SHALL have port out_valid, output, 1 bit, meaning out holds a result.
REQ-010 The module SHALL have port out_ready, input, 1 bit, meaning the consumer takes out this cycle.
REQ-011 The module SHALL have port out, output, 1+EXP_OUT+FRAC_OUT bits, meaning {sign, exp, frac}.

Function
REQ-012 Float format SHALL be as follows: for E>=1, value = {1,f} << (E-1) accumulator LSBs; for E=0, value = f (denormal, implicit 0); sign is sign-magnitude.
REQ-013 A transfer SHALL occur on a rising edge where valid&&ready; in_ready SHALL equal !s3_valid || out_ready (single global stall).
REQ-014 The block SHALL be a 3-stage pipeline: S1 sign/abs; S2 leading-one position p and alignment; S3 round and pack.
REQ-015 Latency SHALL be 3: input accepted at edge N appears with out_valid=1 after edge N+3; throughput SHALL be 1 per cycle when out_ready=1.
REQ-016 While out_valid=1 and out_ready=0, out and all stage registers SHALL hold stable, and in_ready SHALL be 0.
REQ-017 mag = |accIn| computed in ACC_WIDTH unsigned bits; -2^(ACC_WIDTH-1) SHALL yield mag = 2^(ACC_WIDTH-1), not overflow.
REQ-018 mag=0 SHALL produce all-zero out (+0); -0 SHALL never be emitted.
REQ-019 If p < FRAC_OUT: E=0, f=mag[FRAC_OUT-1:0]; if p = FRAC_OUT: E=1, exact.
REQ-020 If p > FRAC_OUT: shift right by s=p-FRAC_OUT; guard = bit s-1, sticky = OR of bits below it; round to nearest, ties to even.
REQ-021 A rounding carry out of {1,f} SHALL set the mantissa to 1.000 and increment E.
REQ-022 If the final E exceeds 2^EXP_OUT-1, out SHALL saturate to max finite magnitude (E all ones, f all ones) with the input sign; no infinity or NaN is produced.
REQ-023 Bubbles (in_valid=0) SHALL propagate as invalid stages without corrupting valid neighbours.

Reset
REQ-024 On reset, s1/s2/s3 valid flags SHALL clear and out_valid=0, out=0, in_ready=1 on the following cycle.
REQ-025 Reset mid-operation SHALL discard all in-flight results; no output SHALL appear for inputs accepted before reset.
REQ-026 Datapath registers other than out need not be reset.

Structure
REQ-027 Package kulisch_pkg SHALL hold the default widths, the float field-offset constants and a packed float struct typedef.
REQ-028 Leading-one detection SHALL be a sub-module kulisch_lzc (parameter WIDTH; outputs position and zero flag), instantiated once in S2.

Verification (defaults; out shown in hex)
REQ-029 accIn = 1, 1500, -3 -> out = 0x0001, 0x05DC, 0x8003 respectively, 3 cycles after acceptance.
REQ-030 accIn = 4097, 4098, 4102 -> out = 0x0C00 (round down), 0x0C00 (tie, even), 0x0C02 (tie, round up).
REQ-031 accIn = 8190 -> mantissa carry; out = 0x1000; accIn = 0x80000000 -> out = 0xD800; accIn = 0 -> out = 0x0000.
REQ-032 Back-to-back stream of 8 inputs with out_ready toggling pseudo-randomly -> outputs in order, none lost or duplicated, out stable while stalled.
REQ-033 Reset asserted with 3 valid items in flight -> out_valid=0 next cycle and none of the 3 items ever emitted.
REQ-034 Saturation: build with EXP_OUT=3, feed accIn = 0x7FFFFFFF -> out = {0, 3'b111, all-ones frac}.
